sha256_stream_core: RTL and testbench

Parametrised SHA-256/SHA-224 engine that hashes a message of NUM_OF_WORDS 32-bit words from the shared testbench dual-port SRAM and writes the digest back to the same memory. It supersedes the fixed 20-word hasher in the same position:

- it streams each 512-bit block straight from memory, with no whole-message buffer;
- it generates padding on the fly for any length;
- it supports a truncated SHA-224 mode.

---
 rtl/sha256_stream_core.sv | 220 ++++++++++++++++++++++
 tb/tb_sha256_stream_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_core.sv
// SHA-256 / SHA-224 engine: streams 512-bit blocks from a synchronous SRAM,
// pads on the fly and writes the digest back to the same memory.
module sha256_stream_core #(
  parameter int NUM_OF_WORDS = 20,
  parameter bit SHA224       = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int          NB       = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam int          DW       = SHA224 ? 7 : 8;
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state_reg, state_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic [11:0] blk_reg, blk_next;
  logic [15:0] msg_base_reg, msg_base_next;
  logic [15:0] out_base_reg, out_base_next;
  logic        mem_we_reg, mem_we_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  logic [31:0] h_reg [8];
  logic [31:0] v_reg [8];
  logic [31:0] w_reg [16];

  logic [15:0] blk_base;
  logic [3:0]  cap_idx;
  logic [15:0] word_idx;
  logic [31:0] cap_word;
  logic [3:0]  t4, i1, i9, i14;
  logic [31:0] w_cur, t1, t2;

  assign done           = (state_reg == IDLE);
  assign mem_clk        = clk;
  assign mem_we         = mem_we_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_write_data = mem_wdata_reg;

  assign blk_base = msg_base_reg + {blk_reg, 4'b0000};
  // Word t of a block arrives one cycle after its address, so slot is cnt-1.
  assign cap_idx  = cnt_reg[3:0] - 4'd1;
  assign word_idx = {blk_reg, 4'b0000} + {12'b0, cap_idx};

  always_comb begin
    if (word_idx < 16'(NUM_OF_WORDS))      cap_word = mem_read_data;
    else if (word_idx == 16'(NUM_OF_WORDS)) cap_word = 32'h8000_0000;
    else if (word_idx == 16'(16 * NB - 1))  cap_word = LEN_BITS;
    else                                    cap_word = 32'h0;
  end

  // Rolling 16-entry schedule window: slot t mod 16 holds W[t-16] on entry.
  assign t4  = cnt_reg[3:0];
  assign i1  = t4 + 4'd1;
  assign i9  = t4 + 4'd9;
  assign i14 = t4 + 4'd14;
  assign w_cur = (cnt_reg < 7'd16) ? w_reg[t4] :
                 w_reg[t4]
                 + (rotr(w_reg[i1], 7) ^ rotr(w_reg[i1], 18) ^ (w_reg[i1] >> 3))
                 + w_reg[i9]
                 + (rotr(w_reg[i14], 17) ^ rotr(w_reg[i14], 19) ^ (w_reg[i14] >> 10));

  assign t1 = v_reg[7]
            + (rotr(v_reg[4], 6) ^ rotr(v_reg[4], 11) ^ rotr(v_reg[4], 25))
            + ((v_reg[4] & v_reg[5]) ^ (~v_reg[4] & v_reg[6]))
            + K[cnt_reg[5:0]] + w_cur;
  assign t2 = (rotr(v_reg[0], 2) ^ rotr(v_reg[0], 13) ^ rotr(v_reg[0], 22))
            + ((v_reg[0] & v_reg[1]) ^ (v_reg[0] & v_reg[2]) ^ (v_reg[1] & v_reg[2]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      blk_reg       <= '0;
      msg_base_reg  <= '0;
      out_base_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      blk_reg       <= blk_next;
      msg_base_reg  <= msg_base_next;
      out_base_reg  <= out_base_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Memory outputs are registered, so each address is set up one cycle early.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    blk_next       = blk_reg;
    msg_base_next  = msg_base_reg;
    out_base_next  = out_base_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = READ;
          cnt_next      = '0;
          blk_next      = '0;
          msg_base_next = message_addr;
          out_base_next = output_addr;
          mem_addr_next = message_addr;
        end
      end
      READ: begin
        if (cnt_reg < 7'd15) mem_addr_next = blk_base + 16'(cnt_reg) + 16'd1;
        if (cnt_reg == 7'd16) begin
          state_next = COMPUTE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      COMPUTE: begin
        if (cnt_reg == 7'd63) begin
          state_next = UPDATE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      UPDATE: begin
        blk_next = blk_reg + 12'd1;
        cnt_next = '0;
        if (blk_reg == 12'(NB - 1)) begin
          state_next = WRITE;
        end else begin
          state_next    = READ;
          mem_addr_next = blk_base + 16'd16;
        end
      end
      WRITE: begin
        if (cnt_reg < 7'(DW)) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = out_base_reg + 16'(cnt_reg);
          mem_wdata_next = h_reg[cnt_reg[2:0]];
        end
        if (cnt_reg == 7'(DW + 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 7'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    case (state_reg)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < 8; i++) h_reg[i] <= SHA224 ? IV224[i] : IV256[i];
        end
      end
      READ: begin
        if (cnt_reg != 7'd0) w_reg[cap_idx] <= cap_word;
        if (cnt_reg == 7'd16) begin
          for (int i = 0; i < 8; i++) v_reg[i] <= h_reg[i];
        end
      end
      COMPUTE: begin
        w_reg[t4] <= w_cur;
        v_reg[7]  <= v_reg[6];
        v_reg[6]  <= v_reg[5];
        v_reg[5]  <= v_reg[4];
        v_reg[4]  <= v_reg[3] + t1;
        v_reg[3]  <= v_reg[2];
        v_reg[2]  <= v_reg[1];
        v_reg[1]  <= v_reg[0];
        v_reg[0]  <= t1 + t2;
      end
      UPDATE: begin
        for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v_reg[i];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: several configurations share one SRAM model;
// expected digest writes are queued at start and checked by a write monitor.
module tb_sha256_stream_core;

  localparam int NCFG = 5;
  localparam int CFG_N [NCFG] = '{20, 13, 14, 1, 4};
  localparam bit CFG_S [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic [31:0] rdata;
  logic        start_v  [NCFG];
  logic        done_v   [NCFG];
  logic        mclk_v   [NCFG];
  logic        we_v     [NCFG];
  logic [15:0] addr_v   [NCFG];
  logic [31:0] wdata_v  [NCFG];

  logic [31:0] mem [0:65535];
  int          sel;
  wr_t         exp_q [$];
  wr_t         mon_e;
  int          wr_count;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    sha256_stream_core #(.NUM_OF_WORDS(CFG_N[gi]), .SHA224(CFG_S[gi])) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start_v[gi]),
      .message_addr   (message_addr),
      .output_addr    (output_addr),
      .done           (done_v[gi]),
      .mem_clk        (mclk_v[gi]),
      .mem_we         (we_v[gi]),
      .mem_addr       (addr_v[gi]),
      .mem_write_data (wdata_v[gi]),
      .mem_read_data  (rdata)
    );
  end

  // Synchronous-read SRAM; digest writes are consumed by the monitor only.
  always @(posedge clk) rdata <= mem[addr_v[sel]];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < NCFG; i++) begin
        if (i != sel && we_v[i]) check(1'b0, "stray_write", 64'(i), 64'(sel));
      end
      if (we_v[sel]) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", {16'h0, addr_v[sel], wdata_v[sel]}, 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check(addr_v[sel] == mon_e.addr && wdata_v[sel] == mon_e.data, "digest_write",
                {16'h0, addr_v[sel], wdata_v[sel]}, {16'h0, mon_e.addr, mon_e.data});
        end
      end
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256/224 over a word message: pad, expand 64 words, compress.
  function automatic void sha_ref(input logic [31:0] msg [$], input bit is224, output logic [31:0] dig [8]);
    logic [31:0] pad [$];
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    pad = msg;
    pad.push_back(32'h8000_0000);
    while (pad.size() % 16 != 14) pad.push_back(32'h0);
    pad.push_back(32'h0);
    pad.push_back(32'(msg.size() * 32));
    for (int i = 0; i < 8; i++) h[i] = is224 ? IV224[i] : IV256[i];
    for (int blk = 0; blk < pad.size() / 16; blk++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = pad[16 * blk + t];
        else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    dig = h;
  endfunction

  task automatic prepare(input int idx, input logic [15:0] maddr, input logic [15:0] oaddr,
                         input bit pattern, input int copies);
    logic [31:0] msg [$];
    logic [31:0] dig [8];
    logic [31:0] wv;
    logic [15:0] a;
    wr_t         ent;
    for (int g = 0; g < CFG_N[idx]; g++) begin
      wv = pattern ? 32'h01234567 + 32'h11111111 * 32'(g) : $urandom;
      a = maddr + 16'(g);
      mem[a] = wv;
      msg.push_back(wv);
    end
    sha_ref(msg, CFG_S[idx], dig);
    for (int c = 0; c < copies; c++) begin
      for (int j = 0; j < (CFG_S[idx] ? 7 : 8); j++) begin
        ent.addr = oaddr + 16'(j);
        ent.data = dig[j];
        exp_q.push_back(ent);
      end
    end
  endtask

  task automatic wait_done(input int idx, input int lat, input bit pulse, input bit addr_chk,
                           input logic [15:0] maddr);
    int k;
    k = 0;
    while (k < 20000) begin
      @(posedge clk);
      #1;
      k++;
      if (pulse) start_v[idx] = (k == 5 || k == lat - 4);
      if (addr_chk && k < 4) check(addr_v[idx] == maddr + 16'(k), "read_addr", 64'(addr_v[idx]), 64'(maddr + 16'(k)));
      if (done_v[idx]) break;
    end
    check(k == lat, "latency", 64'(k), 64'(lat));
  endtask

  task automatic run_hash(input int idx, input logic [15:0] maddr, input logic [15:0] oaddr,
                          input bit pulse, input bit hold, input bit addr_chk);
    int nb, dw, lat;
    nb  = (CFG_N[idx] + 3 + 15) / 16;
    dw  = CFG_S[idx] ? 7 : 8;
    lat = 1 + 82 * nb + dw + 1;
    @(negedge clk);
    sel = idx;
    wr_count = 0;
    message_addr = maddr;
    output_addr  = oaddr;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start_v[idx] = 1'b0;
      message_addr = ~maddr;
      output_addr  = ~oaddr;
    end
    check(done_v[idx] == 1'b0, "done_drop", 64'(done_v[idx]), 64'h0);
    if (addr_chk) check(addr_v[idx] == maddr, "read_addr0", 64'(addr_v[idx]), 64'(maddr));
    wait_done(idx, lat, pulse, addr_chk, maddr);
    if (hold) begin
      @(posedge clk);
      #1;
      start_v[idx] = 1'b0;
      check(done_v[idx] == 1'b0, "restart_drop", 64'(done_v[idx]), 64'h0);
      wait_done(idx, lat, 1'b0, 1'b0, maddr);
    end
    @(negedge clk);
    check(exp_q.size() == 0, "pending_writes", 64'(exp_q.size()), 64'h0);
    check(wr_count == dw * (hold ? 2 : 1), "write_count", 64'(wr_count), 64'(dw * (hold ? 2 : 1)));
    $display("hash cfg=%0d words=%0d sha224=%0d msg=%04h out=%04h writes=%0d", idx, CFG_N[idx],
             CFG_S[idx], maddr, oaddr, wr_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ma, oa;
    sel = 0;
    wr_count = 0;
    message_addr = '0;
    output_addr  = '0;
    for (int i = 0; i < NCFG; i++) start_v[i] = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(done_v[0] == 1'b1, "reset_done", 64'(done_v[0]), 64'h1);
    check(we_v[0] == 1'b0, "reset_we", 64'(we_v[0]), 64'h0);
    check(addr_v[0] == 16'h0, "reset_addr", 64'(addr_v[0]), 64'h0);
    check(wdata_v[0] == 32'h0, "reset_wdata", 64'(wdata_v[0]), 64'h0);
    check(mclk_v[0] == 1'b1, "mem_clk", 64'(mclk_v[0]), 64'h1);
    @(negedge clk) reset_n = 1'b1;

    // Default configuration with the documented message pattern.
    prepare(0, 16'h0000, 16'h0100, 1'b1, 1);
    run_hash(0, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0);

    // Padding boundaries and SHA-224 with random data and addresses.
    for (int idx = 1; idx <= 3; idx++) begin
      ma = 16'($urandom_range(0, 16'hFFFF));
      oa = 16'($urandom_range(0, 16'hFFFF));
      prepare(idx, ma, oa, 1'b0, 1);
      run_hash(idx, ma, oa, 1'b0, 1'b0, 1'b0);
    end

    // Message straddling the top of the address space.
    oa = 16'($urandom_range(16'h1000, 16'h8000));
    prepare(4, 16'hFFFE, oa, 1'b0, 1);
    run_hash(4, 16'hFFFE, oa, 1'b0, 1'b0, 1'b1);

    // Reset while block 0 is being compressed.
    @(negedge clk);
    sel = 0;
    message_addr = 16'h0040;
    output_addr  = 16'h0200;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check(done_v[0] == 1'b1, "midreset_done", 64'(done_v[0]), 64'h1);
    check(we_v[0] == 1'b0, "midreset_we", 64'(we_v[0]), 64'h0);
    check(addr_v[0] == 16'h0, "midreset_addr", 64'(addr_v[0]), 64'h0);
    check(wdata_v[0] == 32'h0, "midreset_wdata", 64'(wdata_v[0]), 64'h0);
    @(negedge clk) reset_n = 1'b1;
    exp_q.delete();
    ma = 16'($urandom_range(0, 16'hFFFF));
    oa = 16'($urandom_range(0, 16'hFFFF));
    prepare(0, ma, oa, 1'b0, 1);
    run_hash(0, ma, oa, 1'b0, 1'b0, 1'b0);

    // start pulses in READ and WRITE must be ignored.
    ma = 16'($urandom_range(0, 16'hFFFF));
    oa = 16'($urandom_range(0, 16'hFFFF));
    prepare(0, ma, oa, 1'b0, 1);
    run_hash(0, ma, oa, 1'b1, 1'b0, 1'b0);

    // start held high: a second identical hash follows immediately.
    ma = 16'($urandom_range(0, 16'hFFFF));
    oa = 16'($urandom_range(0, 16'hFFFF));
    prepare(1, ma, oa, 1'b0, 2);
    run_hash(1, ma, oa, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
